// File: rtl/llfifo_pop_sched.sv
// llfifo_pop_sched
//   Occupancy tracker and pop scheduler for the shared-pointer multi-queue
//   linked-list FIFO. Keeps a per-queue entry count from accepted pushes and
//   pops. Offers one pop per cycle to the datapath as a valid/ready command,
//   choosing among non-empty queues round-robin. Push is back-pressured
//   when the shared pointer pool (PTR_N-1 usable entries, pointer 0 is null)
//   is exhausted.
//
//   Optional feature macro: LLFIFO_SCHED_WRR_EN
//     defined   -> weighted round-robin: a granted queue keeps the grant for
//                  up to cfg_weight[id] (0 counts as 1) consecutive accepted
//                  pops while it stays non-empty.
//     undefined -> plain round-robin, no cfg_weight port.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   push_vld/push_id    push request and its target queue
//   push_rdy            push accepted when push_vld & push_rdy (= !full)
//   pop_vld/pop_id      registered pop command, stable until pop_rdy
//   pop_rdy             datapath accepts the pop
//   cfg_weight          (WRR only) 4-bit weight per queue
//   empty               per-queue empty flags, registered
//   full                pool exhausted, registered
//   total               total occupied entries, registered
module llfifo_pop_sched #(
  parameter int ID_N  = 4,
  parameter int PTR_N = 255,
  parameter int CNT_W = $clog2(PTR_N),
  localparam int ID_W = (ID_N > 1) ? $clog2(ID_N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [ID_W-1:0]  push_id,
  output logic             push_rdy,
  output logic             pop_vld,
  output logic [ID_W-1:0]  pop_id,
  input  logic             pop_rdy,
`ifdef LLFIFO_SCHED_WRR_EN
  input  logic [ID_N*4-1:0] cfg_weight,
`endif
  output logic [ID_N-1:0]  empty,
  output logic             full,
  output logic [CNT_W-1:0] total
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [ID_N-1:0][CNT_W-1:0] cnt_q, cnt_nxt;
  logic [CNT_W-1:0]         total_q, total_d;
  logic [ID_N-1:0]          empty_q, empty_d;
  logic                     full_q, full_d;
  logic                     pop_vld_q, pop_vld_d;
  logic [ID_W-1:0]          pop_id_q, pop_id_d;
  logic [ID_W-1:0]          rr_last_q, rr_last_d;
  logic [ID_W-1:0]          arb_base, grant;
  logic                     found, push_acc, pop_acc, stay;
`ifdef LLFIFO_SCHED_WRR_EN
  logic [3:0]               burst_q, burst_d, grant_wt;
`endif

  assign push_rdy = !full_q;
  assign push_acc = push_vld & push_rdy;
  assign pop_acc  = pop_vld_q & pop_rdy;

  // Counts after this edge's push and pop; arbitration and flags use these
  // so that a same-cycle push or pop is already accounted for.
  always_comb begin
    cnt_nxt = cnt_q;
    for (int i = 0; i < ID_N; i++) begin
      if (push_acc && push_id == ID_W'(i))
        cnt_nxt[i] = cnt_nxt[i] + CNT_W'(1);
      if (pop_acc && pop_id_q == ID_W'(i))
        cnt_nxt[i] = cnt_nxt[i] - CNT_W'(1);
    end
    total_d = total_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
    full_d  = (total_d == CNT_W'(PTR_N - 1));
    for (int i = 0; i < ID_N; i++)
      empty_d[i] = (cnt_nxt[i] == '0);
  end

  // Round-robin search starting one past the last granted id. When a pop is
  // being accepted, that id becomes rr_last at this same edge, so search
  // from it instead of the stale rr_last_q.
  always_comb begin
    int idx;
    idx      = 0;
    arb_base = (state_q == OFFER) ? pop_id_q : rr_last_q;
    found    = 1'b0;
    grant    = '0;
    for (int k = 1; k <= ID_N; k++) begin
      idx = int'(arb_base) + k;
      if (idx >= ID_N) idx = idx - ID_N;
      if (!found && cnt_nxt[idx] != '0) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

`ifdef LLFIFO_SCHED_WRR_EN
  always_comb begin
    grant_wt = cfg_weight[int'(grant)*4 +: 4];
    if (grant_wt == 4'd0) grant_wt = 4'd1;
    // Keep the current queue while its burst has pops left and it still
    // holds entries after this accept.
    stay = (burst_q > 4'd1) && (cnt_nxt[pop_id_q] != '0);
  end
`else
  assign stay = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pop_vld_d = pop_vld_q;
    pop_id_d  = pop_id_q;
    rr_last_d = rr_last_q;
`ifdef LLFIFO_SCHED_WRR_EN
    burst_d   = burst_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = OFFER;
          pop_vld_d = 1'b1;
          pop_id_d  = grant;
`ifdef LLFIFO_SCHED_WRR_EN
          burst_d   = grant_wt;
`endif
        end
      end
      OFFER: begin
        // Without pop_rdy the offer is held unchanged.
        if (pop_rdy) begin
          if (stay) begin
`ifdef LLFIFO_SCHED_WRR_EN
            burst_d = burst_q - 4'd1;
`endif
          end else begin
            rr_last_d = pop_id_q;
            if (found) begin
              pop_id_d = grant;
`ifdef LLFIFO_SCHED_WRR_EN
              burst_d  = grant_wt;
`endif
            end else begin
              state_d   = IDLE;
              pop_vld_d = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pop_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      total_q   <= '0;
      empty_q   <= '1;
      full_q    <= 1'b0;
      pop_vld_q <= 1'b0;
      pop_id_q  <= '0;
      rr_last_q <= ID_W'(ID_N - 1);
`ifdef LLFIFO_SCHED_WRR_EN
      burst_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_nxt;
      total_q   <= total_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      pop_vld_q <= pop_vld_d;
      pop_id_q  <= pop_id_d;
      rr_last_q <= rr_last_d;
`ifdef LLFIFO_SCHED_WRR_EN
      burst_q   <= burst_d;
`endif
    end
  end

  assign pop_vld = pop_vld_q;
  assign pop_id  = pop_id_q;
  assign empty   = empty_q;
  assign full    = full_q;
  assign total   = total_q;

endmodule

// File: tb/tb_llfifo_pop_sched.sv
// Directed bench for llfifo_pop_sched (ID_N=4, PTR_N=255).
module tb_llfifo_pop_sched;
  logic       clk, rst;
  logic       push_vld, pop_rdy;
  logic [1:0] push_id;
  logic       push_rdy, pop_vld, full;
  logic [1:0] pop_id;
  logic [3:0] empty;
  logic [7:0] total;
`ifdef LLFIFO_SCHED_WRR_EN
  logic [15:0] cfg_weight;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  llfifo_pop_sched #(.ID_N(4), .PTR_N(255)) dut (
    .clk(clk), .rst(rst),
    .push_vld(push_vld), .push_id(push_id), .push_rdy(push_rdy),
    .pop_vld(pop_vld), .pop_id(pop_id), .pop_rdy(pop_rdy),
`ifdef LLFIFO_SCHED_WRR_EN
    .cfg_weight(cfg_weight),
`endif
    .empty(empty), .full(full), .total(total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1; push_vld = 1'b0; push_id = '0; pop_rdy = 1'b0;
`ifdef LLFIFO_SCHED_WRR_EN
    cfg_weight = '0;  // all weights act as 1 -> plain round-robin
`endif
    tick();
    chk("rst_pop_vld", pop_vld, 0);
    chk("rst_pop_id", pop_id, 0);
    chk("rst_empty", empty, 4'hF);
    chk("rst_full", full, 0);
    chk("rst_total", total, 0);
    chk("rst_push_rdy", push_rdy, 1);
    rst = 1'b0;
    tick();

    // Push id2 x3 with pop held off.
    push_vld = 1'b1; push_id = 2'd2;
    tick();
    chk("lat_pop_vld", pop_vld, 1);
    chk("lat_pop_id", pop_id, 2);
    chk("lat_total", total, 1);
    tick(); tick();
    push_vld = 1'b0;
    chk("id2_empty", empty, 4'b1011);
    chk("id2_total", total, 3);
    tick(); tick();
    chk("hold_pop_vld", pop_vld, 1);
    chk("hold_pop_id", pop_id, 2);
    pop_rdy = 1'b1;
    tick(); tick(); tick();
    pop_rdy = 1'b0;
    chk("drain2_pop_vld", pop_vld, 0);
    chk("drain2_total", total, 0);
    chk("drain2_empty", empty, 4'hF);

    // Two entries in each queue, then back-to-back round-robin pops.
    push_vld = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push_id = 2'(k % 4);
      tick();
    end
    push_vld = 1'b0;
    chk("rr_load_total", total, 8);
    pop_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rr_vld%0d", k), pop_vld, 1);
      chk($sformatf("rr_id%0d", k), pop_id, 32'(k % 4));
      tick();
    end
    pop_rdy = 1'b0;
    chk("rr_end_pop_vld", pop_vld, 0);
    chk("rr_end_empty", empty, 4'hF);

    // Fill the pool to PTR_N-1 = 254 entries.
    push_vld = 1'b1;
    for (int k = 0; k < 254; k++) begin
      push_id = 2'(k % 4);
      tick();
    end
    chk("fill_full", full, 1);
    chk("fill_push_rdy", push_rdy, 0);
    chk("fill_total", total, 254);
    chk("fill_pop_id", pop_id, 0);
    push_id = 2'd3;
    tick();  // push attempted while full: must be ignored
    push_vld = 1'b0;
    chk("full_ignore_total", total, 254);
    chk("full_ignore_full", full, 1);
    pop_rdy = 1'b1;
    tick();
    pop_rdy = 1'b0;
    chk("unfull_full", full, 0);
    chk("unfull_push_rdy", push_rdy, 1);
    chk("unfull_total", total, 253);
    chk("unfull_pop_id", pop_id, 1);
    pop_rdy = 1'b1;
    cyc = 0;
    while (pop_vld && cyc < 300) begin
      tick();
      cyc++;
    end
    pop_rdy = 1'b0;
    chk("drain_pop_vld", pop_vld, 0);
    chk("drain_total", total, 0);
    chk("drain_empty", empty, 4'hF);

    // Same-id push and accepted pop on one edge.
    push_vld = 1'b1; push_id = 2'd1;
    tick();
    chk("same_pre_pop_id", pop_id, 1);
    pop_rdy = 1'b1;
    tick();
    push_vld = 1'b0;
    chk("same_pop_vld", pop_vld, 1);
    chk("same_pop_id", pop_id, 1);
    chk("same_total", total, 1);
    chk("same_empty", empty, 4'b1101);
    tick();
    pop_rdy = 1'b0;
    chk("same_end_pop_vld", pop_vld, 0);
    chk("same_end_empty", empty, 4'hF);

    // Asynchronous reset with an unaccepted offer pending.
    push_vld = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push_id = 2'((k + 1) % 4);
      tick();
    end
    push_vld = 1'b0;
    chk("pre_rst_total", total, 5);
    chk("pre_rst_pop_vld", pop_vld, 1);
    chk("pre_rst_pop_id", pop_id, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_pop_vld", pop_vld, 0);
    chk("arst_pop_id", pop_id, 0);
    chk("arst_total", total, 0);
    chk("arst_empty", empty, 4'hF);
    chk("arst_full", full, 0);
    chk("arst_push_rdy", push_rdy, 1);
    tick();
    rst = 1'b0;
    push_vld = 1'b1; push_id = 2'd0;
    tick();
    push_vld = 1'b0;
    chk("post_rst_pop_vld", pop_vld, 1);
    chk("post_rst_pop_id", pop_id, 0);
    chk("post_rst_total", total, 1);

`ifdef LLFIFO_SCHED_WRR_EN
    begin
      int exp_seq[8] = '{0, 3, 3, 3, 0, 3, 3, 3};
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cfg_weight = 16'h3111;  // queue 3 weight 3, others 1
      push_vld = 1'b1;
      push_id = 2'd0;
      for (int k = 0; k < 3; k++) tick();
      push_id = 2'd3;
      for (int k = 0; k < 6; k++) tick();
      push_vld = 1'b0;
      pop_rdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("wrr_id%0d", k), pop_id, 32'(exp_seq[k]));
        tick();
      end
      pop_rdy = 1'b0;
      chk("wrr_total", total, 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
